// File: rtl/branch_pred_queue.sv
// branch_pred_queue: in-order queue of in-flight branch predictions with training update and redirect.
// Define BPQ_GHR_REPAIR_EN to store per-entry GHR snapshots and emit repair_valid/repair_ghr.
module branch_pred_queue #(
    parameter int DEPTH     = 4,
    parameter int GHR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_pc,
    input  logic                     enq_pred_taken,
    input  logic [31:0]              enq_pred_target,
    input  logic [GHR_WIDTH-1:0]     enq_ghr,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [31:0]              res_target,
    input  logic                     res_is_cond,
    output logic                     upd_valid,
    output logic [31:0]              upd_pc,
    output logic                     upd_taken,
    output logic                     upd_is_cond,
    output logic                     mispredict,
    output logic [31:0]              redirect_pc,
    output logic                     repair_valid,
    output logic [GHR_WIDTH-1:0]     repair_ghr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]    pc_q  [DEPTH];
    logic [31:0]    tgt_q [DEPTH];
    logic [DEPTH-1:0] tk_q;
    logic [AW-1:0]  head, tail;
    logic           empty, push, pop, mis, clr, pop_ok, mis_ok;
    assign empty     = count == '0;
    assign enq_ready = count != CW'(DEPTH);
    assign push      = enq_valid && enq_ready;
    assign pop       = res_valid && !empty;
    assign mis       = pop && ((tk_q[head] != res_taken) || (res_taken && tgt_q[head] != res_target));
    assign clr       = flush || mis;
    assign pop_ok    = pop && !flush;
    assign mis_ok    = mis && !flush;

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            pc_q[tail]  <= enq_pc;
            tgt_q[tail] <= enq_pred_target;
            tk_q[tail]  <= enq_pred_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            upd_valid     <= 1'b0;
            upd_pc        <= '0;
            upd_taken     <= 1'b0;
            upd_is_cond   <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            underflow_err <= 1'b0;
        end else begin
            upd_valid     <= pop_ok;
            mispredict    <= mis_ok;
            underflow_err <= underflow_err || (res_valid && empty);
            if (pop_ok) begin
                upd_pc      <= pc_q[head];
                upd_taken   <= res_taken;
                upd_is_cond <= res_is_cond;
            end
            if (mis_ok)
                redirect_pc <= res_taken ? res_target : pc_q[head] + 32'd4;
            // a mispredict makes every younger entry wrong-path, so it clears like a flush
            if (clr) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + AW'(pop);
                tail  <= tail + AW'(push);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef BPQ_GHR_REPAIR_EN
    logic [GHR_WIDTH-1:0] ghr_q [DEPTH];
    always_ff @(posedge clk) begin
        if (push && !clr)
            ghr_q[tail] <= enq_ghr;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repair_valid <= 1'b0;
            repair_ghr   <= '0;
        end else begin
            repair_valid <= mis_ok;
            if (mis_ok)
                repair_ghr <= res_is_cond ? {ghr_q[head][GHR_WIDTH-2:0], res_taken} : ghr_q[head];
        end
    end
`else
    logic unused_ghr;
    assign unused_ghr   = ^enq_ghr;
    assign repair_valid = 1'b0;
    assign repair_ghr   = '0;
`endif
endmodule

// File: tb/tb_branch_pred_queue.sv
// tb_branch_pred_queue: table-driven directed check of branch_pred_queue plus wrap, underflow and reset sequences.
module tb_branch_pred_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, enq_valid = 1'b0, enq_pred_taken = 1'b0;
    logic [31:0] enq_pc = '0, enq_pred_target = '0, res_target = '0;
    logic [9:0]  enq_ghr = '0;
    logic        res_valid = 1'b0, res_taken = 1'b0, res_is_cond = 1'b0;
    logic        enq_ready, upd_valid, upd_taken, upd_is_cond, mispredict, repair_valid, underflow_err;
    logic [31:0] upd_pc, redirect_pc;
    logic [9:0]  repair_ghr;
    logic [2:0]  count;
    int total = 0;
    int bad = 0;

    branch_pred_queue #(.DEPTH(4), .GHR_WIDTH(10)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
        .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target), .enq_ghr(enq_ghr),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target), .res_is_cond(res_is_cond),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_is_cond(upd_is_cond),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .repair_valid(repair_valid), .repair_ghr(repair_ghr),
        .count(count), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, ev, pt, rv, rt, rc;
        logic [31:0] pc, ptg, rtg;
        logic [9:0]  ghr;
        logic [2:0]  cnt;
        logic        uv, ut, mp, uf;
        logic [31:0] upc, rpc;
        logic [9:0]  rg;
    } vec_t;

    function automatic vec_t mk(input logic fl, ev, input logic [31:0] pc, input logic pt,
                                input logic [31:0] ptg, input logic [9:0] ghr, input logic rv, rt,
                                input logic [31:0] rtg, input logic rc, input logic [2:0] cnt,
                                input logic uv, input logic [31:0] upc, input logic ut, mp,
                                input logic [31:0] rpc, input logic [9:0] rg, input logic uf);
        vec_t v;
        v.fl = fl; v.ev = ev; v.pc = pc; v.pt = pt; v.ptg = ptg; v.ghr = ghr;
        v.rv = rv; v.rt = rt; v.rtg = rtg; v.rc = rc;
        v.cnt = cnt; v.uv = uv; v.upc = upc; v.ut = ut; v.mp = mp; v.rpc = rpc; v.rg = rg; v.uf = uf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        flush = v.fl; enq_valid = v.ev; enq_pc = v.pc; enq_pred_taken = v.pt;
        enq_pred_target = v.ptg; enq_ghr = v.ghr; res_valid = v.rv; res_taken = v.rt;
        res_target = v.rtg; res_is_cond = v.rc;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " count"}, 32'(count), 32'(v.cnt));
        chk({tag, " enq_ready"}, 32'(enq_ready), 32'(v.cnt != 3'd4));
        chk({tag, " upd_valid"}, 32'(upd_valid), 32'(v.uv));
        chk({tag, " mispredict"}, 32'(mispredict), 32'(v.mp));
        chk({tag, " underflow_err"}, 32'(underflow_err), 32'(v.uf));
        if (v.uv) begin
            chk({tag, " upd_pc"}, upd_pc, v.upc);
            chk({tag, " upd_taken"}, 32'(upd_taken), 32'(v.ut));
            chk({tag, " upd_is_cond"}, 32'(upd_is_cond), 32'(v.rc));
        end
        if (v.mp) chk({tag, " redirect_pc"}, redirect_pc, v.rpc);
`ifdef BPQ_GHR_REPAIR_EN
        chk({tag, " repair_valid"}, 32'(repair_valid), 32'(v.mp));
        if (v.mp) chk({tag, " repair_ghr"}, 32'(repair_ghr), 32'(v.rg));
`else
        chk({tag, " repair_valid"}, 32'(repair_valid), 32'd0);
        chk({tag, " repair_ghr"}, 32'(repair_ghr), 32'd0);
`endif
    endtask

    vec_t vt[19];

    initial begin
        //        fl ev pc            pt ptg       ghr     rv rt rtg       rc cnt uv upc           ut mp rpc      rg      uf
        vt[0]  = mk(0, 1, 32'h100,      0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[1]  = mk(0, 1, 32'h104,      0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 2, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[2]  = mk(0, 1, 32'h108,      0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 3, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[3]  = mk(0, 1, 32'h10C,      0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 4, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[4]  = mk(0, 1, 32'h110,      0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 4, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[5]  = mk(0, 1, 32'h110,      0, 32'h0,   10'h0,   1, 0, 32'h0,   1, 3, 1, 32'h100,      0, 0, 32'h0,   10'h0,  0);
        vt[6]  = mk(0, 1, 32'h114,      0, 32'h0,   10'h0,   1, 0, 32'h0,   1, 3, 1, 32'h104,      0, 0, 32'h0,   10'h0,  0);
        vt[7]  = mk(0, 1, 32'h118,      0, 32'h0,   10'h0,   1, 1, 32'h500, 1, 0, 1, 32'h108,      1, 1, 32'h500, 10'h1,  0);
        vt[8]  = mk(0, 0, 32'h0,        0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[9]  = mk(0, 1, 32'h200,      1, 32'h240, 10'h3FF, 0, 0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[10] = mk(0, 1, 32'h204,      0, 32'h0,   10'h0,   1, 1, 32'h280, 0, 0, 1, 32'h200,      1, 1, 32'h280, 10'h3FF, 0);
        vt[11] = mk(0, 1, 32'h300,      1, 32'h340, 10'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[12] = mk(0, 0, 32'h0,        0, 32'h0,   10'h0,   1, 1, 32'h340, 0, 0, 1, 32'h300,      1, 0, 32'h0,   10'h0,  0);
        vt[13] = mk(0, 1, 32'hFFFFFFFC, 1, 32'h10,  10'h155, 0, 0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[14] = mk(0, 0, 32'h0,        0, 32'h0,   10'h0,   1, 0, 32'h0,   1, 0, 1, 32'hFFFFFFFC, 0, 1, 32'h0,   10'h2AA, 0);
        vt[15] = mk(0, 1, 32'h400,      0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 1, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[16] = mk(0, 1, 32'h404,      0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 2, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[17] = mk(1, 1, 32'h408,      0, 32'h0,   10'h0,   1, 0, 32'h0,   1, 0, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);
        vt[18] = mk(0, 0, 32'h0,        0, 32'h0,   10'h0,   0, 0, 32'h0,   0, 0, 0, 32'h0,        0, 0, 32'h0,   10'h0,  0);

        @(negedge clk);
        chk("reset count", 32'(count), 32'd0);
        chk("reset enq_ready", 32'(enq_ready), 32'd1);
        chk("reset upd_valid", 32'(upd_valid), 32'd0);
        chk("reset upd_pc", upd_pc, 32'd0);
        chk("reset upd_taken", 32'(upd_taken), 32'd0);
        chk("reset upd_is_cond", 32'(upd_is_cond), 32'd0);
        chk("reset mispredict", 32'(mispredict), 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'd0);
        chk("reset underflow_err", 32'(underflow_err), 32'd0);
        chk("reset repair_valid", 32'(repair_valid), 32'd0);
        chk("reset repair_ghr", 32'(repair_ghr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) apply(vt[i], $sformatf("vec%0d", i));

        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1), "underflow");
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "underflow_hold");

        apply(mk(0, 1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), "wrap_fill");
        for (int k = 1; k <= 12; k++)
            apply(mk(0, 1, 32'h1000 + 32'(4 * k), 0, 0, 0, 1, 0, 0, 1, 1, 1,
                     32'h1000 + 32'(4 * (k - 1)), 0, 0, 0, 0, 1), $sformatf("wrap%0d", k));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 32'h1030, 0, 0, 0, 0, 1), "wrap_drain");

        apply(mk(0, 1, 32'h2000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), "pre_rst0");
        apply(mk(0, 1, 32'h2004, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1), "pre_rst1");
        enq_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst count", 32'(count), 32'd0);
        chk("async_rst enq_ready", 32'(enq_ready), 32'd1);
        chk("async_rst underflow_err", 32'(underflow_err), 32'd0);
        chk("async_rst upd_pc", upd_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "post_rst_empty");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
